// File: rtl/uart_rx.sv
// UART receiver: 2-flop synced line, mid-bit sampling, LSB-first frames into a one-word holding register.
// Word appears CLKS_PER_BIT/2+(DATA_W+1)*CLKS_PER_BIT+1 clocks after start detect; no backpressure, a full register drops the word (out_ovr).
module uart_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 244
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_rx,
  input  logic              in_ack,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_urx_bs,
  output logic              out_frm_err,
  output logic              out_ovr
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [TW-1:0] HALF_T   = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_T   = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic              r_sync1;
  logic              r_rx_s;
  logic [2:0]        r_state;
  logic [TW-1:0]     r_timer;
  logic [BW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_done;
  logic              r_frm_err;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_ovr;

  logic w_half;
  logic w_full;

  assign w_half = (r_timer == HALF_T);
  assign w_full = (r_timer == FULL_T);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_done    <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_sync1   <= in_rx;
      r_rx_s    <= r_sync1;
      r_done    <= 1'b0;
      r_frm_err <= 1'b0;
      // BREAK can last arbitrarily long, so its timer is parked at zero instead of counting.
      if (r_state == S_IDLE || r_state == S_BREAK) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TW'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_timer <= '0;
          end
        end
        S_START: begin
          if (w_half) begin
            r_timer <= '0;
            if (!r_rx_s) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (w_full) begin
            r_timer <= '0;
            r_shift <= {r_rx_s, r_shift[DATA_W-1:1]};
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        S_STOP: begin
          // Leaving mid-stop-bit lets a back-to-back start edge be caught.
          if (w_full) begin
            r_timer <= '0;
            if (r_rx_s) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_BREAK;
              r_frm_err <= 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_timer <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (r_done) begin
        // An ack in the completion cycle frees the register just in time for the new word.
        if (!r_valid || in_ack) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (in_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data    = r_data;
  assign out_valid   = r_valid;
  assign out_urx_bs  = (r_state != S_IDLE);
  assign out_frm_err = r_frm_err;
  assign out_ovr     = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed cases plus a random frame sweep with random consumer acks.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int DW  = 8;
  localparam int CPB = 16;

  logic          in_clk = 1'b0;
  logic          in_rst_n = 1'b0;
  logic          in_rx = 1'b1;
  logic          in_ack = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_urx_bs;
  logic          out_frm_err;
  logic          out_ovr;

  always #5 in_clk = ~in_clk;

  uart_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .in_clk     (in_clk),
    .in_rst_n   (in_rst_n),
    .in_rx      (in_rx),
    .in_ack     (in_ack),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_urx_bs (out_urx_bs),
    .out_frm_err(out_frm_err),
    .out_ovr    (out_ovr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;
  int ovr_seen = 0;
  int ferr_seen = 0;
  int ovr_exp = 0;
  int ferr_exp = 0;
  bit held = 1'b0;
  int lat;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  // Reference model: one-word holding register; a word finding it full (and not being acked) is dropped.
  task automatic model_frame(input logic [7:0] d, input bit ack_at_done);
    if (held && !ack_at_done) begin
      ovr_exp++;
    end else begin
      exp_q.push_back(d);
      held = 1'b1;
    end
  endtask

  task automatic ack_pulse();
    in_ack = 1'b1;
    tick();
    in_ack = 1'b0;
    held = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      in_rx = bits[i];
      repeat (CPB) tick();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, out_urx_bs, 0);
    check({tag, "_ferr"}, out_frm_err, 0);
    check({tag, "_ovr"}, out_ovr, 0);
  endtask

  always @(negedge in_clk) begin
    if (in_rst_n) begin
      if (in_ack && out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rx_word: got %02h, expected no word (queue empty)", out_data);
        end else begin
          exp_w = exp_q.pop_front();
          check("rx_word", out_data, exp_w);
        end
      end
      if (out_ovr) ovr_seen++;
      if (out_frm_err) ferr_seen++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected run completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    repeat (3) tick();
    check_idle_outputs("reset");
    in_rst_n = 1'b1;
    repeat (4) tick();

    // Single good frame with latency measurement
    model_frame(8'hA5, 1'b0);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        lat = 0;
        while (!out_valid && lat < 400) begin
          tick();
          lat++;
        end
      end
    join
    n_cmp++;
    if (lat < 154 || lat > 156) begin
      n_bad++;
      $display("FAIL a5_latency: got %0d clocks, expected 154..156", lat);
    end
    check("a5_data", out_data, 8'hA5);
    check("a5_ferr_cnt", ferr_seen, ferr_exp);
    check("a5_ovr_cnt", ovr_seen, ovr_exp);
    ack_pulse();
    repeat (4) tick();

    // Short low glitch on idle line
    in_rx = 1'b0;
    repeat (6) tick();
    in_rx = 1'b1;
    repeat (6) tick();
    check("glitch_busy", out_urx_bs, 0);
    check("glitch_valid", out_valid, 0);
    check("glitch_ferr_cnt", ferr_seen, ferr_exp);
    repeat (8) tick();

    // Framing error followed by a held-low line, then recovery
    ferr_exp++;
    send_frame(8'h3C, 1'b0);
    repeat (40) tick();
    in_rx = 1'b1;
    repeat (20) tick();
    check("ferr_cnt", ferr_seen, ferr_exp);
    check("ferr_valid", out_valid, 0);
    model_frame(8'h81, 1'b0);
    send_frame(8'h81, 1'b1);
    check("after_ferr_data", out_data, 8'h81);
    ack_pulse();
    repeat (4) tick();

    // Back-to-back with no ack: second word dropped
    model_frame(8'h11, 1'b0);
    model_frame(8'h22, 1'b0);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (4) tick();
    check("ovr_data_kept", out_data, 8'h11);
    check("ovr_cnt", ovr_seen, ovr_exp);
    ack_pulse();
    repeat (4) tick();

    // Back-to-back with ack exactly in the completion cycle of the second frame
    model_frame(8'h11, 1'b0);
    model_frame(8'h22, 1'b1);
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
      end
      begin
        repeat (160 + 155) tick();
        in_ack = 1'b1;
        tick();
        in_ack = 1'b0;
      end
    join
    repeat (4) tick();
    check("ackdone_data", out_data, 8'h22);
    check("ackdone_valid", out_valid, 1);
    check("ackdone_ovr_cnt", ovr_seen, ovr_exp);
    ack_pulse();
    repeat (4) tick();

    // Reset during data bit 4 while a word is being held
    model_frame(8'h5A, 1'b0);
    send_frame(8'h5A, 1'b1);
    check("prereset_valid", out_valid, 1);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (5 * CPB + 8) tick();
        in_rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        exp_q.delete();
        held = 1'b0;
        repeat (3) tick();
        in_rst_n = 1'b1;
      end
    join
    repeat (20) tick();
    model_frame(8'h00, 1'b0);
    send_frame(8'h00, 1'b1);
    check("postreset_valid", out_valid, 1);
    ack_pulse();
    repeat (4) tick();
    check("directed_queue_empty", exp_q.size(), 0);

    // Random sweep
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      model_frame(d, 1'b0);
      send_frame(d, 1'b1);
      if ($urandom_range(0, 1) == 1) ack_pulse();
      repeat ($urandom_range(0, 12)) tick();
    end
    repeat (4) tick();
    if (held) ack_pulse();
    repeat (4) tick();
    check("sweep_queue_empty", exp_q.size(), 0);
    check("sweep_ovr_cnt", ovr_seen, ovr_exp);
    check("sweep_ferr_cnt", ferr_seen, ferr_exp);
    check("sweep_valid_clear", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
